uart_tx_buffered: RTL and testbench

Buffered UART transmitter. It accepts payload words over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `uart_txd` as start/data/stop frames. It is the transmit-side counterpart of the receive path in `uart_top`: the host-facing serialiser that drives a remote receiver's `rxd` line, replacing the single-byte unbuffered TX in echo and streaming designs.

---
 rtl/uart_tx_buffered.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter emitting LSB-first start/data/stop frames.
// Define UART_TX_PARITY_EN to insert one even-parity bit between the data and stop bits.
module uart_tx_buffered #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PAYLOAD_BITS-1:0]       in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    logic                    r_parity;
`endif

    logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W:0]          r_count;
    logic [2:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [3:0]              r_idx;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_txd;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_bit_end;
    logic [PAYLOAD_BITS-1:0] w_head;

    assign in_ready   = (r_count != COUNT_FULL);
    assign w_push     = in_valid && in_ready;
    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_head     = r_mem[r_rd_ptr];
    // Pops happen from IDLE, or at the very end of the last stop bit for gapless frames.
    assign w_pop      = (r_count != '0) &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_STOP) && w_bit_end && (r_idx == STOP_LAST)));

    assign uart_txd   = r_txd;
    assign tx_busy    = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_count = r_count;

    // NOTE: storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    // NOTE: all state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_txd    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_cnt    <= '0;
                        r_txd    <= 1'b0;
                        r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == DATA_LAST) begin
                            r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx != STOP_LAST) begin
                            r_idx <= r_idx + 4'd1;
                        end else if (w_pop) begin
                            r_idx    <= '0;
                            r_shift  <= w_head;
                            r_txd    <= 1'b0;
                            r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                        end else begin
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: per-cycle frame-timing model, bit-centre line decoder,
// directed scenarios and randomized traffic.
module tb_uart_tx_buffered;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 100_000;
    localparam int PB       = 8;
    localparam int SB       = 1;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int PAR      = 1;
`else
    localparam int PAR      = 0;
`endif
    localparam int NBITS    = 1 + PB + PAR + SB;
    localparam int FRAME    = NBITS * CPB;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] in_data  = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_tx_buffered #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB),
        .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .uart_txd(uart_txd), .tx_busy(tx_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a word queue plus the position inside the current frame.
    logic [7:0] m_q[$];
    logic [7:0] sent_q[$];
    bit         m_in_frame = 1'b0;
    logic [7:0] m_word     = '0;
    int         m_pos      = 0;
    bit         m_push;
    bit         m_popped;
    logic [7:0] m_w;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            sent_q.delete();
            m_in_frame = 1'b0;
            m_pos      = 0;
        end else begin
            m_push   = in_valid && (m_q.size() != DEPTH);
            m_popped = 1'b0;
            if (m_q.size() != 0 && (!m_in_frame || m_pos == FRAME - 1)) begin
                m_w      = m_q.pop_front();
                m_popped = 1'b1;
            end
            if (m_push) begin
                m_q.push_back(in_data);
                sent_q.push_back(in_data);
            end
            if (m_popped) begin
                m_word     = m_w;
                m_pos      = 0;
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                if (m_pos == FRAME - 1) m_in_frame = 1'b0;
                else                    m_pos++;
            end
        end
    end

    function automatic logic exp_txd();
        int b;
        if (!m_in_frame) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= PB) return m_word[b-1];
        if (PAR == 1 && b == PB + 1) return ^m_word;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("txd",   uart_txd,   exp_txd());
        check("count", fifo_count, m_q.size());
        check("ready", in_ready,   m_q.size() != DEPTH);
        check("busy",  tx_busy,    m_in_frame || m_q.size() != 0);
    end

    // Line decoder: samples bit centres and checks words against acceptance order.
    bit               d_active   = 1'b0;
    int               d_off      = 0;
    int               d_fall_cyc = 0;
    int               frames_done = 0;
    logic [NBITS-1:0] d_bits     = '0;
    logic [NBITS-1:0] last_bits  = '0;
    logic [7:0]       d_word;
    logic [7:0]       dec_log[$];

    always @(negedge clk) begin
        if (reset) begin
            d_active = 1'b0;
        end else if (!d_active) begin
            if (uart_txd == 1'b0) begin
                d_active   = 1'b1;
                d_off      = 0;
                d_fall_cyc = cyc;
            end
        end else begin
            d_off++;
        end
        if (d_active && (d_off % CPB) == CPB / 2) begin
            d_bits[d_off / CPB] = uart_txd;
            if (d_off / CPB == NBITS - 1) begin
                d_active = 1'b0;
                d_word   = d_bits[PB:1];
                check("dec_start", d_bits[0], 1'b0);
                check("dec_stop",  d_bits[NBITS-1], 1'b1);
`ifdef UART_TX_PARITY_EN
                check("dec_parity", d_bits[PB+1], ^d_word);
`endif
                if (sent_q.size() == 0) check("dec_unexpected_frame", d_word, 32'hFFFF_FFFF);
                else                    check("dec_word", d_word, sent_q.pop_front());
                last_bits = d_bits;
                dec_log.push_back(d_word);
                frames_done++;
            end
        end
    end

    int peak_count = 0;
    bit saw_full   = 1'b0;
    always @(negedge clk) begin
        if (fifo_count > peak_count) peak_count = fifo_count;
        if (fifo_count == 3'd4 && in_ready == 1'b0) saw_full = 1'b1;
    end

    // Tasks are entered 1 time unit after a rising edge.
    int last_push_cyc = 0;
    task automatic push_word(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((tx_busy || d_active) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    int exp_bits_41[NBITS];
    int t0;
    int n_acc;
    int budget;
    int rst_at;
    int prob;
    int frames_before;

    initial begin
`ifdef UART_TX_PARITY_EN
        exp_bits_41 = '{0, 1,0,0,0,0,0,1,0, 0, 1};
`else
        exp_bits_41 = '{0, 1,0,0,0,0,0,1,0, 1};
`endif
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd",   uart_txd,   1'b1);
        check("rst_ready", in_ready,   1'b1);
        check("rst_busy",  tx_busy,    1'b0);
        check("rst_count", fifo_count, 3'd0);
        reset = 1'b0;

        // Single word 0x41
        push_word(8'h41);
        check("single_count_after_push", fifo_count, 3'd1);
        t0 = 0;
        while (tx_busy && t0 < 2 * FRAME) begin @(posedge clk); #1; t0++; end
        check("single_fall_latency", d_fall_cyc - last_push_cyc, 1);
        check("single_frame_len", cyc - d_fall_cyc, FRAME);
`ifdef UART_TX_PARITY_EN
        check("single_frame_len_lit", cyc - d_fall_cyc, 110);
`else
        check("single_frame_len_lit", cyc - d_fall_cyc, 100);
`endif
        for (int i = 0; i < NBITS; i++) check($sformatf("single_bit%0d", i), last_bits[i], exp_bits_41[i]);
        check("single_word", dec_log.size() == 1 ? dec_log[0] : 8'hxx, 8'h41);
        dec_log.delete();

        // Back-to-back 0x55, 0xAA, 0x00
        peak_count = 0;
        in_valid = 1'b1;
        in_data  = 8'h55; @(posedge clk); #1; t0 = cyc;
        in_data  = 8'hAA; @(posedge clk); #1;
        in_data  = 8'h00; @(posedge clk); #1;
        in_valid = 1'b0;
        n_acc = 0;
        while (tx_busy && n_acc < 4 * FRAME) begin @(posedge clk); #1; n_acc++; end
        check("b2b_total_len", cyc - t0 - 1, 3 * FRAME);
        check("b2b_peak_count", peak_count, 2);
        check("b2b_nframes", dec_log.size(), 3);
        if (dec_log.size() == 3) begin
            check("b2b_w0", dec_log[0], 8'h55);
            check("b2b_w1", dec_log[1], 8'hAA);
            check("b2b_w2", dec_log[2], 8'h00);
        end
        dec_log.delete();

        // Full FIFO with incrementing data
        peak_count = 0;
        saw_full   = 1'b0;
        in_data    = 8'h10;
        in_valid   = 1'b1;
        n_acc      = 0;
        budget     = 0;
        while (n_acc < 10 && budget < 20 * FRAME) begin
            logic rdy;
            rdy = in_ready;
            @(posedge clk); #1;
            budget++;
            if (rdy) begin n_acc++; in_data = in_data + 8'd1; end
        end
        in_valid = 1'b0;
        check("full_accepted", n_acc, 10);
        wait_idle("full_drain", 8 * FRAME);
        check("full_peak", peak_count, 4);
        check("full_ready_low_seen", saw_full, 1'b1);
        check("full_nframes", dec_log.size(), 10);
        for (int i = 0; i < 10 && i < dec_log.size(); i++)
            check($sformatf("full_w%0d", i), dec_log[i], 8'h10 + i);
        dec_log.delete();

        // Randomized traffic with one asynchronous reset
        rst_at = $urandom_range(300, 1200);
        for (int i = 0; i < 1600; i++) begin
            prob = (i < 800) ? 60 : 2;
            if (i == rst_at)     reset = 1'b1;
            if (i == rst_at + 2) reset = 1'b0;
            in_valid = !reset && ($urandom_range(0, prob - 1) == 0);
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle("rand_drain", 8 * FRAME);
        check("rand_all_decoded", sent_q.size(), 0);
        dec_log.delete();

        // Reset during data bit 3 of the first frame
        in_valid = 1'b1;
        in_data  = 8'hDE; @(posedge clk); #1; t0 = cyc;
        in_data  = 8'hAD; @(posedge clk); #1;
        in_valid = 1'b0;
        budget = 0;
        while (cyc < t0 + 1 + 4 * CPB + CPB / 2 && budget < FRAME) begin @(posedge clk); #1; budget++; end
        check("rstmid_pre_count", fifo_count, 3'd1);
        check("rstmid_pre_busy", tx_busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rstmid_txd", uart_txd, 1'b1);
        check("rstmid_count", fifo_count, 3'd0);
        check("rstmid_busy", tx_busy, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        frames_before = frames_done;
        push_word(8'hBE);
        wait_idle("rstmid_drain", 3 * FRAME);
        repeat (2 * FRAME) @(posedge clk);
        #1;
        check("rstmid_nframes", frames_done - frames_before, 1);
        check("rstmid_word", dec_log.size() == 1 ? dec_log[0] : 8'hxx, 8'hBE);
        dec_log.delete();

`ifdef UART_TX_PARITY_EN
        // Parity bit values and frame length
        push_word(8'h07);
        t0 = 0;
        while (tx_busy && t0 < 2 * FRAME) begin @(posedge clk); #1; t0++; end
        check("par07_len", cyc - d_fall_cyc, 110);
        check("par07_bit", last_bits[9], 1'b1);
        push_word(8'h03);
        wait_idle("par03_drain", 2 * FRAME);
        check("par03_bit", last_bits[9], 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
